// File: rtl/axi_read_sched.sv
// Round-robin read sequencer for two requesters in front of axi_read_block.
// Splits each request into bursts of at most MAX_CHUNK bytes that never cross a 4 KB page.
//
// state | meaning
// IDLE  | arbitrating between req0/req1
// ISSUE | computing next burst, waiting for rb_busy low to pulse rb_start
// WAIT  | burst in flight, waiting for rb_done
// DONE  | signalling completion, updating round-robin pointer
module axi_read_sched #(
    parameter int MAX_CHUNK = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic [15:0] req0_size,
    output logic        req0_ready,
    output logic        req0_done,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic [15:0] req1_size,
    output logic        req1_ready,
    output logic        req1_done,
    output logic        rb_start,
    output logic [31:0] rb_addr,
    output logic [15:0] rb_size,
    input  logic        rb_busy,
    input  logic        rb_done,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [15:0] MAX_CHUNK_W = 16'(MAX_CHUNK);

    state_t      state_q, state_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] chunk_q, chunk_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_id_q, grant_id_d;
    logic        req0_ready_q, req0_ready_d;
    logic        req1_ready_q, req1_ready_d;
    logic        req0_done_q, req0_done_d;
    logic        req1_done_q, req1_done_d;
    logic        rb_start_q, rb_start_d;
    logic [31:0] rb_addr_q, rb_addr_d;
    logic [15:0] rb_size_q, rb_size_d;
    logic        busy_q, busy_d;

    logic [12:0] page_left;
    logic [15:0] chunk_c;
    logic        sel;
    logic [31:0] sel_addr;
    logic [15:0] sel_size;

    // Burst length: min of remaining bytes, MAX_CHUNK and bytes left in the 4 KB page.
    always_comb begin
        page_left = 13'h1000 - {1'b0, cur_addr_q[11:0]};
        chunk_c   = remaining_q;
        if (chunk_c > MAX_CHUNK_W) begin
            chunk_c = MAX_CHUNK_W;
        end
        if (chunk_c > {3'b000, page_left}) begin
            chunk_c = {3'b000, page_left};
        end
    end

    always_comb begin
        sel      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        sel_addr = sel ? req1_addr : req0_addr;
        sel_size = sel ? req1_size : req0_size;
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        chunk_d      = chunk_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        req0_ready_d = 1'b0;
        req1_ready_d = 1'b0;
        req0_done_d  = 1'b0;
        req1_done_d  = 1'b0;
        rb_start_d   = 1'b0;
        rb_addr_d    = rb_addr_q;
        rb_size_d    = rb_size_q;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_id_d   = sel;
                    req0_ready_d = ~sel;
                    req1_ready_d = sel;
                    cur_addr_d   = sel_addr & ~32'h3;
                    remaining_d  = sel_size & ~16'h3;
                    state_d      = (remaining_d == 16'h0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!rb_busy) begin
                    rb_start_d = 1'b1;
                    rb_addr_d  = cur_addr_q;
                    rb_size_d  = chunk_c;
                    chunk_d    = chunk_c;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (rb_done) begin
                    cur_addr_d  = cur_addr_q + {16'h0, chunk_q};
                    remaining_d = remaining_q - chunk_q;
                    if (remaining_q == chunk_q) begin
                        req0_done_d = ~grant_id_q;
                        req1_done_d = grant_id_q;
                        state_d     = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                // Done already pulsed on the WAIT exit; only zero-size requests pulse here.
                if (!(req0_done_q || req1_done_q)) begin
                    req0_done_d = ~grant_id_q;
                    req1_done_d = grant_id_q;
                end
                last_grant_d = grant_id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_addr_q   <= 32'h0;
            remaining_q  <= 16'h0;
            chunk_q      <= 16'h0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            req0_done_q  <= 1'b0;
            req1_done_q  <= 1'b0;
            rb_start_q   <= 1'b0;
            rb_addr_q    <= 32'h0;
            rb_size_q    <= 16'h0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            chunk_q      <= chunk_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            req0_ready_q <= req0_ready_d;
            req1_ready_q <= req1_ready_d;
            req0_done_q  <= req0_done_d;
            req1_done_q  <= req1_done_d;
            rb_start_q   <= rb_start_d;
            rb_addr_q    <= rb_addr_d;
            rb_size_q    <= rb_size_d;
            busy_q       <= busy_d;
        end
    end

    assign req0_ready = req0_ready_q;
    assign req1_ready = req1_ready_q;
    assign req0_done  = req0_done_q;
    assign req1_done  = req1_done_q;
    assign rb_start   = rb_start_q;
    assign rb_addr    = rb_addr_q;
    assign rb_size    = rb_size_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_axi_read_sched.sv
// Scoreboard bench for axi_read_sched: expected bursts and grants are queued when a
// request is driven and popped as rb_start / reqN_ready appear.
module tb_axi_read_sched;

    localparam int MAX_CHUNK = 64;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr;
    logic [15:0] req0_size, req1_size;
    logic        req0_ready, req1_ready, req0_done, req1_done;
    logic        rb_start;
    logic [31:0] rb_addr;
    logic [15:0] rb_size;
    logic        rb_busy, rb_done;
    logic        busy, grant_id;

    axi_read_sched #(.MAX_CHUNK(MAX_CHUNK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_size  (req0_size),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_size  (req1_size),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .rb_start   (rb_start),
        .rb_addr    (rb_addr),
        .rb_size    (rb_size),
        .rb_busy    (rb_busy),
        .rb_done    (rb_done),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int rdy_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int resp = 0;
    logic prev_done0 = 1'b0;
    logic prev_done1 = 1'b0;

    logic [47:0] exp_burst [$];
    logic        exp_grant [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor and rb_done responder (burst completes 3 cycles after rb_start).
    initial begin
        logic [47:0] eb;
        logic        eg;
        rb_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                resp    = 0;
                rb_done = 1'b0;
            end else begin
                rb_done = 1'b0;
                if (resp > 0) begin
                    resp--;
                    if (resp == 0) rb_done = 1'b1;
                end
                if (rb_start) begin
                    start_cnt++;
                    resp = 3;
                    chk("burst_pending", 32'(exp_burst.size() != 0), 32'd1);
                    if (exp_burst.size() != 0) begin
                        eb = exp_burst.pop_front();
                        chk("burst_addr", rb_addr, eb[47:16]);
                        chk("burst_size", 32'(rb_size), 32'(eb[15:0]));
                    end
                end
                if (req0_ready || req1_ready) begin
                    chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
                    chk("grant_pending", 32'(exp_grant.size() != 0), 32'd1);
                    if (exp_grant.size() != 0) begin
                        eg = exp_grant.pop_front();
                        chk("grant_order", 32'(req1_ready), 32'(eg));
                        chk("grant_id", 32'(grant_id), 32'(eg));
                    end
                end
                if (req0_ready) rdy_cnt[0]++;
                if (req1_ready) rdy_cnt[1]++;
                if (req0_done) begin
                    done_cnt[0]++;
                    chk("done0_width", 32'(prev_done0), 32'd0);
                end
                if (req1_done) begin
                    done_cnt[1]++;
                    chk("done1_width", 32'(prev_done1), 32'd0);
                end
            end
            prev_done0 = req0_done;
            prev_done1 = req1_done;
        end
    end

    task automatic set_req(input bit id, input bit v, input logic [31:0] a, input logic [15:0] s);
        if (id) begin
            req1_valid = v; req1_addr = a; req1_size = s;
        end else begin
            req0_valid = v; req0_addr = a; req0_size = s;
        end
    endtask

    task automatic do_req(input bit id, input logic [31:0] addr, input logic [15:0] size,
                          input int stall);
        logic [31:0] a;
        int rem, c, bnd, nb, s0, t_rdy, t_done, o_rdy, o_done, m_rdy, m_done;
        bit seen;
        a = addr & ~32'h3;
        rem = int'(size & ~16'h3);
        nb = 0;
        while (rem > 0) begin
            c = rem;
            if (c > MAX_CHUNK) c = MAX_CHUNK;
            bnd = 4096 - int'(a & 32'hFFF);
            if (c > bnd) c = bnd;
            exp_burst.push_back({a, 16'(c)});
            a = a + 32'(c);
            rem = rem - c;
            nb++;
        end
        exp_grant.push_back(id);
        s0 = start_cnt;
        o_rdy = rdy_cnt[!id]; o_done = done_cnt[!id];
        m_rdy = rdy_cnt[id];  m_done = done_cnt[id];
        t_rdy = 0; t_done = 0;
        if (stall > 0) rb_busy = 1'b1;
        set_req(id, 1'b1, addr, size);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (id ? req1_ready : req0_ready) begin seen = 1; t_rdy = cyc; end
        end
        chk("ready_seen", 32'(seen), 32'd1);
        set_req(id, 1'b0, addr, size);
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; end
            chk("stall_hold", 32'(start_cnt - s0), 32'd0);
            rb_busy = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk); #1;
            if (id ? req1_done : req0_done) begin seen = 1; t_done = cyc; end
        end
        chk("done_seen", 32'(seen), 32'd1);
        @(negedge clk); #1;
        chk("burst_count", 32'(start_cnt - s0), 32'(nb));
        chk("bursts_left", 32'(exp_burst.size()), 32'd0);
        chk("own_ready_cnt", 32'(rdy_cnt[id] - m_rdy), 32'd1);
        chk("own_done_cnt", 32'(done_cnt[id] - m_done), 32'd1);
        chk("other_ready_cnt", 32'(rdy_cnt[!id] - o_rdy), 32'd0);
        chk("other_done_cnt", 32'(done_cnt[!id] - o_done), 32'd0);
        if (nb == 0) chk("zero_done_lat", 32'(t_done - t_rdy), 32'd1);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_rb_addr"}, rb_addr, 32'd0);
        chk({tag, "_rb_size"}, 32'(rb_size), 32'd0);
        chk({tag, "_ctl"}, 32'({req0_ready, req0_done, req1_ready, req1_done,
                                rb_start, busy, grant_id}), 32'd0);
    endtask

    initial begin
        bit seen, gid;
        int d0;
        rst_n = 1'b1;
        rb_busy = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_size = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_size = '0;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Arbitration: both requesters contend, expected order 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            exp_grant.push_back(k[0]);
            if (k[0]) exp_burst.push_back({32'h800, 16'd12});
            else      exp_burst.push_back({32'h400, 16'd8});
        end
        set_req(0, 1'b1, 32'h400, 16'd8);
        set_req(1, 1'b1, 32'h800, 16'd12);
        for (int k = 0; k < 4; k++) begin
            seen = 0; gid = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(posedge clk); #1;
                if (req0_ready || req1_ready) begin seen = 1; gid = req1_ready; end
            end
            chk("arb_ready_seen", 32'(seen), 32'd1);
            if (gid) req1_valid = 1'b0; else req0_valid = 1'b0;
            seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(posedge clk); #1;
                if (gid ? req1_done : req0_done) seen = 1;
            end
            chk("arb_done_seen", 32'(seen), 32'd1);
            if (k < 2) begin
                if (gid) req1_valid = 1'b1; else req0_valid = 1'b1;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("arb_grants_left", 32'(exp_grant.size()), 32'd0);
        chk("arb_bursts_left", 32'(exp_burst.size()), 32'd0);

        do_req(0, 32'h100, 16'd8, 0);
        do_req(1, 32'h0, 16'd200, 0);
        do_req(0, 32'hFF0, 16'd64, 0);
        do_req(1, 32'h7, 16'd3, 0);
        do_req(0, 32'h2000, 16'd16, 5);

        // Reset during WAIT: outputs clear at once and no done appears.
        exp_grant.push_back(1'b0);
        exp_burst.push_back({32'h300, 16'd16});
        set_req(0, 1'b1, 32'h300, 16'd16);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (req0_ready) req0_valid = 1'b0;
            if (rb_start) seen = 1;
        end
        chk("mw_start_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        chk("mw_busy_before", 32'(busy), 32'd1);
        d0 = done_cnt[0];
        rst_n = 1'b0;
        #1;
        chk_outs_zero("mw_reset");
        repeat (5) @(posedge clk);
        #1;
        chk("mw_no_done", 32'(done_cnt[0] - d0), 32'd0);
        chk_outs_zero("mw_held");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_req(0, 32'h200, 16'd4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got=running expected=finished");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_read_sched.md
# axi_read_sched

Sequencer and arbiter in front of `axi_read_block`, shared by two read requesters (QSPI prefetch path and register-side DMA). It accepts one byte-sized read request at a time by round-robin arbitration. It splits each request into bursts no larger than `MAX_CHUNK` bytes that never cross a 4 KB address boundary, and drives `axi_read_block`'s `start`/`addr`/`transfer_size` once per burst. It reports completion to the winning requester.

## Interface
- `MAX_CHUNK`, 64, maximum burst length in bytes; power of two, 4..4096.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a request; address and size must be held stable until `req0_ready`.
- `req0_addr`  in  32  start byte address; bits [1:0] ignored (treated as 0).
- `req0_size`  in  16  length in bytes; bits [1:0] ignored.
- `req0_ready`  out  1  one-cycle pulse: request accepted.
- `req0_done`  out  1  one-cycle pulse: all bursts complete.
- `req1_valid`, `req1_addr`, `req1_size`, `req1_ready`, `req1_done`: same as requester 0.
- `rb_start`  out  1  one-cycle burst start to `axi_read_block`.
- `rb_addr`  out  32  burst address, registered, valid while `rb_start`=1.
- `rb_size`  out  16  burst length in bytes, a multiple of 4, valid while `rb_start`=1.
- `rb_busy`  in  1  `axi_read_block` busy.
- `rb_done`  in  1  `axi_read_block` burst-complete pulse.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  1  owner of the current or most recent request.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - If exactly one `reqN_valid` is high, grant it.
  - If both are high, grant the requester other than `last_grant`. `last_grant` resets to 1, so requester 0 wins first.
  - On grant: latch `cur_addr` = addr with [1:0] cleared, and `remaining` = size with [1:0] cleared.
  - Pulse `reqN_ready` and set `grant_id`.
  - Next state is ISSUE, or DONE if `remaining` = 0.
- ISSUE
  - `chunk` = min(`remaining`, `MAX_CHUNK`, 4096 − `cur_addr`[11:0]). Compute the boundary term 13 bits wide; `chunk` is 16 bits.
  - If `rb_busy` = 0: pulse `rb_start` with `rb_addr`=`cur_addr` and `rb_size`=`chunk`, latch `chunk`, go to WAIT.
  - If `rb_busy` = 1: hold in ISSUE.
- WAIT
  - On `rb_done`: `cur_addr` += `chunk` (mod 2^32) and `remaining` −= `chunk`.
  - Next state is DONE if `remaining` reaches 0, else ISSUE.
  - `rb_busy` is ignored in WAIT.
- DONE: pulse `reqN_done` for the granted requester, set `last_grant` = `grant_id`, go to IDLE.
- `reqN_valid` is ignored outside IDLE. A requester must deassert `valid` after `ready` or it re-arbitrates on the next IDLE cycle.
- `rb_done` outside WAIT is ignored.

## Timing
- Reset values: all outputs 0, including `rb_addr`, `rb_size` and `grant_id`. State is IDLE and `last_grant` is 1. Reset mid-transfer aborts immediately with no `done` pulse. `axi_read_block` shares `rst_n`.
- All outputs are registered.
- Request acceptance:
  - `valid` sampled high in IDLE at edge E0.
  - `reqN_ready` is high for the cycle after E0.
  - `rb_start` is high for the cycle after E1, provided `rb_busy` = 0 at E1.
- Burst completion:
  - For a non-final burst, `rb_done` sampled at edge Ek gives ISSUE in the cycle after Ek and the next `rb_start` in the cycle after Ek+1.
  - For the final burst, `rb_done` sampled at Ek gives `reqN_done` in the cycle after Ek. IDLE follows, and a new grant is possible at Ek+2.
- Zero-size request (size < 4): `ready` pulse, then a `done` pulse in the following cycle. No `rb_start` is issued.
- Never more than one `rb_start` per `rb_done`.
- `ready` and `done` pulses are exactly 1 cycle wide.

## Test plan
- Single request: req0 addr 0x100, size 8; bench models `rb_done` 3 cycles after `rb_start`.
  - Required: exactly one `rb_start` with `rb_addr`=0x100, `rb_size`=8; one `req0_ready`; one `req0_done`; `req1_*` stay 0.
- Chunking: req1 addr 0x0, size 200, `MAX_CHUNK`=64.
  - Required: bursts (0x00,64), (0x40,64), (0x80,64), (0xC0,8), then one `req1_done`.
- 4 KB boundary: addr 0xFF0, size 64.
  - Required: bursts (0xFF0,16), then (0x1000,48).
- Arbitration: both valid, re-asserted after every `done`, for 4 requests.
  - Required: grant order 0,1,0,1; `grant_id` matches each `ready`.
- Degenerate size and busy stall:
  - size 3: `ready`, then `done` one cycle later, no `rb_start`.
  - Hold `rb_busy`=1 for 5 cycles in ISSUE: `rb_start` is delayed until `rb_busy`=0.
- Reset mid-WAIT: assert `rst_n`=0 during WAIT.
  - Required: all outputs 0 asynchronously; no `done`. A new req0 (0x200, 4) completes normally.
